// File: rtl/fb_rect_fill_if.sv
// Command handshake and framebuffer write-port bundle for fb_rect_fill.
// The cmd_clear signal exists only when FB_RECT_CLEAR_EN is defined.
interface fb_rect_fill_if #(
  parameter int XW         = 9,
  parameter int YW         = 8,
  parameter int MEM_WIDTH  = 8,
  parameter int ADDR_WIDTH = 17
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [XW-1:0]         cmd_x0, cmd_x1;
  logic [YW-1:0]         cmd_y0, cmd_y1;
  logic [MEM_WIDTH-1:0]  cmd_color;
`ifdef FB_RECT_CLEAR_EN
  logic                  cmd_clear;
`endif
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_WIDTH-1:0]  din;
  logic                  wen;

`ifdef FB_RECT_CLEAR_EN
  modport master (output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_clear,
                  input  cmd_ready, busy, done, mem_addr, din, wen);
  modport slave  (input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color, cmd_clear,
                  output cmd_ready, busy, done, mem_addr, din, wen);
`else
  modport master (output cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
                  input  cmd_ready, busy, done, mem_addr, din, wen);
  modport slave  (input  cmd_valid, cmd_x0, cmd_x1, cmd_y0, cmd_y1, cmd_color,
                  output cmd_ready, busy, done, mem_addr, din, wen);
`endif
endinterface

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine feeding the framebuffer write port, one pixel per clock.
// Define FB_RECT_CLEAR_EN to add the cmd_clear full-frame clear command.
module fb_rect_fill #(
  parameter int RES_X      = 320,
  parameter int RES_Y      = 240,
  parameter int MEM_WIDTH  = 8,
  parameter int ADDR_WIDTH = $clog2(RES_X*RES_Y),
  parameter int XW         = $clog2(RES_X),
  parameter int YW         = $clog2(RES_Y)
) (
  input  logic          clk,
  input  logic          rst,
  fb_rect_fill_if.slave bus
);

  localparam logic [XW-1:0]         X_MAX   = XW'(RES_X-1);
  localparam logic [YW-1:0]         Y_MAX   = YW'(RES_Y-1);
  localparam logic [ADDR_WIDTH-1:0] RES_X_A = ADDR_WIDTH'(RES_X);

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_e;

  state_e                state_q;
  logic [XW-1:0]         x0_q, x1_q, xl_q, xr_q, x_q;
  logic [YW-1:0]         y0_q, y1_q, yb_q, y_q;
  logic [MEM_WIDTH-1:0]  color_q, din_q;
  logic [ADDR_WIDTH-1:0] row_base_q, addr_q;
  logic                  wen_q, done_q;
`ifdef FB_RECT_CLEAR_EN
  logic                  clr_q;
`endif

  // Clamp first, then order: equivalent result, and keeps the compares narrow.
  logic [XW-1:0]         cx0, cx1, xl_d, xr_d;
  logic [YW-1:0]         cy0, cy1, yt_d, yb_d;
  logic [ADDR_WIDTH-1:0] row_base_d;

  always_comb begin
    cx0  = (x0_q > X_MAX) ? X_MAX : x0_q;
    cx1  = (x1_q > X_MAX) ? X_MAX : x1_q;
    cy0  = (y0_q > Y_MAX) ? Y_MAX : y0_q;
    cy1  = (y1_q > Y_MAX) ? Y_MAX : y1_q;
    xl_d = (cx0 < cx1) ? cx0 : cx1;
    xr_d = (cx0 < cx1) ? cx1 : cx0;
    yt_d = (cy0 < cy1) ? cy0 : cy1;
    yb_d = (cy0 < cy1) ? cy1 : cy0;
`ifdef FB_RECT_CLEAR_EN
    if (clr_q) begin
      xl_d = '0;
      xr_d = X_MAX;
      yt_d = '0;
      yb_d = Y_MAX;
    end
`endif
    row_base_d = ADDR_WIDTH'(yt_d) * RES_X_A;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      xl_q       <= '0;
      xr_q       <= '0;
      x_q        <= '0;
      yb_q       <= '0;
      y_q        <= '0;
      color_q    <= '0;
      din_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
`ifdef FB_RECT_CLEAR_EN
      clr_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.cmd_valid) begin
            x0_q    <= bus.cmd_x0;
            x1_q    <= bus.cmd_x1;
            y0_q    <= bus.cmd_y0;
            y1_q    <= bus.cmd_y1;
            color_q <= bus.cmd_color;
`ifdef FB_RECT_CLEAR_EN
            clr_q   <= bus.cmd_clear;
`endif
            state_q <= SETUP;
          end
        end
        SETUP: begin
          // First write's outputs are loaded here so wen rises right after SETUP.
          xl_q       <= xl_d;
          xr_q       <= xr_d;
          yb_q       <= yb_d;
          x_q        <= xl_d;
          y_q        <= yt_d;
          row_base_q <= row_base_d;
          addr_q     <= row_base_d + ADDR_WIDTH'(xl_d);
          din_q      <= color_q;
          wen_q      <= 1'b1;
          state_q    <= FILL;
        end
        FILL: begin
          if (x_q != xr_q) begin
            x_q    <= x_q + 1'b1;
            addr_q <= addr_q + 1'b1;
          end else if (y_q != yb_q) begin
            x_q        <= xl_q;
            y_q        <= y_q + 1'b1;
            row_base_q <= row_base_q + RES_X_A;
            addr_q     <= row_base_q + RES_X_A + ADDR_WIDTH'(xl_q);
          end else begin
            wen_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == IDLE) & ~rst;
  assign bus.busy      = (state_q != IDLE) & ~rst;
  assign bus.done      = done_q;
  assign bus.mem_addr  = addr_q;
  assign bus.din       = din_q;
  assign bus.wen       = wen_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: logs every framebuffer write and done pulse,
// then compares them against hand-computed addresses, data and cycle numbers.
module tb_fb_rect_fill;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [16:0] wa[$];
  logic [7:0]  wd[$];
  int          wc[$];
  int          dc[$];

  fb_rect_fill_if #(.XW(9), .YW(8), .MEM_WIDTH(8), .ADDR_WIDTH(17)) bus ();

  fb_rect_fill dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.wen) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.din);
      wc.push_back(cyc);
    end
    if (bus.done) dc.push_back(cyc);
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); wc.delete(); dc.delete();
  endtask

  task automatic issue(input logic [8:0] x0, input logic [8:0] x1, input logic [7:0] y0,
                       input logic [7:0] y1, input logic [7:0] col, output int hs);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready_timeout: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.cmd_x0 = x0; bus.cmd_x1 = x1; bus.cmd_y0 = y0; bus.cmd_y1 = y1;
    bus.cmd_color = col;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    hs = cyc;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b1;
    bus.cmd_x0 = 9'd1; bus.cmd_x1 = 9'd1; bus.cmd_y0 = 8'd1; bus.cmd_y1 = 8'd1;
    bus.cmd_color = 8'hFF;
`ifdef FB_RECT_CLEAR_EN
    bus.cmd_clear = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b required 0", bus.cmd_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    checks++; if (bus.wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b required 0", bus.wen); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", bus.done); end
    checks++; if (bus.mem_addr !== 17'd0) begin errors++; $display("FAIL reset_addr: got %0d required 0", bus.mem_addr); end
    checks++; if (bus.din !== 8'd0) begin errors++; $display("FAIL reset_din: got %0h required 0", bus.din); end
    bus.cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b required 1", bus.cmd_ready); end
  endtask

  task automatic test_single_pixel();
    int hs;
    clear_log();
    issue(9'd5, 9'd5, 8'd7, 8'd7, 8'h30, hs);
    repeat (6) @(negedge clk);
    checks++; if (wa.size() !== 1) begin errors++; $display("FAIL single_count: got %0d writes required 1", wa.size()); end
    if (wa.size() >= 1) begin
      checks++; if (wa[0] !== 17'd2245) begin errors++; $display("FAIL single_addr: got %0d required 2245", wa[0]); end
      checks++; if (wd[0] !== 8'h30) begin errors++; $display("FAIL single_din: got %0h required 30", wd[0]); end
      checks++; if (wc[0] !== hs + 1) begin errors++; $display("FAIL single_latency: write cycle %0d required %0d", wc[0], hs + 1); end
    end
    checks++; if (dc.size() !== 1) begin errors++; $display("FAIL single_done_count: got %0d required 1", dc.size()); end
    else begin
      checks++; if (dc[0] !== hs + 2) begin errors++; $display("FAIL single_done_cycle: got %0d required %0d", dc[0], hs + 2); end
    end
  endtask

  // Runs the 3x2 rectangle with corners given in both orders.
  task automatic test_small_rect();
    int hs;
    int n;
    logic [16:0] exp_a[6];
    exp_a = '{17'd0, 17'd1, 17'd2, 17'd320, 17'd321, 17'd322};
    for (int pass = 0; pass < 2; pass++) begin
      clear_log();
      if (pass == 0) issue(9'd0, 9'd2, 8'd0, 8'd1, 8'h0C, hs);
      else           issue(9'd2, 9'd0, 8'd1, 8'd0, 8'h0C, hs);
      n = 0;
      while (cyc < hs + 8 && n < 50) begin
        @(negedge clk);
        n++;
      end
      checks++; if (wa.size() !== 6) begin errors++; $display("FAIL rect%0d_count: got %0d required 6", pass, wa.size()); end
      for (int i = 0; i < 6 && i < wa.size(); i++) begin
        checks++;
        if (wa[i] !== exp_a[i] || wd[i] !== 8'h0C || wc[i] !== hs + 1 + i) begin
          errors++;
          $display("FAIL rect%0d_write%0d: addr %0d din %0h cyc %0d required addr %0d din 0c cyc %0d",
                   pass, i, wa[i], wd[i], wc[i], exp_a[i], hs + 1 + i);
        end
      end
      checks++; if (dc.size() !== 1 || dc[0] !== hs + 7) begin errors++; $display("FAIL rect%0d_done: count %0d required 1 at cycle %0d", pass, dc.size(), hs + 7); end
      checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rect%0d_ready_after_done: got %b required 1", pass, bus.cmd_ready); end
    end
  endtask

  task automatic test_clamp();
    int hs;
    clear_log();
    issue(9'd318, 9'd400, 8'd239, 8'd239, 8'h03, hs);
    repeat (8) @(negedge clk);
    checks++; if (wa.size() !== 2) begin errors++; $display("FAIL clamp_count: got %0d required 2", wa.size()); end
    if (wa.size() >= 2) begin
      checks++; if (wa[0] !== 17'd76798) begin errors++; $display("FAIL clamp_addr0: got %0d required 76798", wa[0]); end
      checks++; if (wa[1] !== 17'd76799) begin errors++; $display("FAIL clamp_addr1: got %0d required 76799", wa[1]); end
      checks++; if (wd[1] !== 8'h03) begin errors++; $display("FAIL clamp_din: got %0h required 03", wd[1]); end
    end
    checks++; if (dc.size() !== 1 || dc[0] !== hs + 3) begin errors++; $display("FAIL clamp_done: count %0d required 1 at cycle %0d", dc.size(), hs + 3); end
  endtask

  task automatic test_back_to_back();
    int hs1, hs2, n;
    clear_log();
    issue(9'd0, 9'd1, 8'd0, 8'd0, 8'h11, hs1);
    // Second command held valid while the first is still running.
    bus.cmd_x0 = 9'd10; bus.cmd_x1 = 9'd10; bus.cmd_y0 = 8'd0; bus.cmd_y1 = 8'd0;
    bus.cmd_color = 8'h22;
    bus.cmd_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 50);
    @(posedge clk);
    #1;
    hs2 = cyc;
    bus.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (hs2 !== hs1 + 5) begin errors++; $display("FAIL b2b_period: second accept at %0d required %0d", hs2, hs1 + 5); end
    checks++; if (wa.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d required 3", wa.size()); end
    if (wa.size() >= 3) begin
      checks++; if (wa[0] !== 17'd0 || wd[0] !== 8'h11 || wc[0] !== hs1 + 1) begin errors++; $display("FAIL b2b_w0: addr %0d din %0h cyc %0d required 0 11 %0d", wa[0], wd[0], wc[0], hs1 + 1); end
      checks++; if (wa[1] !== 17'd1 || wd[1] !== 8'h11 || wc[1] !== hs1 + 2) begin errors++; $display("FAIL b2b_w1: addr %0d din %0h cyc %0d required 1 11 %0d", wa[1], wd[1], wc[1], hs1 + 2); end
      checks++; if (wa[2] !== 17'd10 || wd[2] !== 8'h22 || wc[2] !== hs2 + 1) begin errors++; $display("FAIL b2b_w2: addr %0d din %0h cyc %0d required 10 22 %0d", wa[2], wd[2], wc[2], hs2 + 1); end
    end
    checks++; if (dc.size() !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d required 2", dc.size()); end
  endtask

  task automatic test_reset_mid_fill();
    int hs, n;
    clear_log();
    issue(9'd0, 9'd9, 8'd0, 8'd9, 8'h3F, hs);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (wa.size() < 3 && n < 50);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.wen !== 1'b0) begin errors++; $display("FAIL abort_wen: got %b required 0", bus.wen); end
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_in_rst: got %b required 0", bus.cmd_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_after: got %b required 1", bus.cmd_ready); end
    repeat (5) @(negedge clk);
    checks++; if (wa.size() !== 3) begin errors++; $display("FAIL abort_write_count: got %0d required 3", wa.size()); end
    else begin
      checks++; if (wa[2] !== 17'd2) begin errors++; $display("FAIL abort_last_addr: got %0d required 2", wa[2]); end
    end
    checks++; if (dc.size() !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses required 0", dc.size()); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", bus.busy); end
  endtask

`ifdef FB_RECT_CLEAR_EN
  task automatic test_clear();
    int hs, n, bad;
    clear_log();
    bus.cmd_clear = 1'b1;
    issue(9'd5, 9'd6, 8'd5, 8'd6, 8'h00, hs);
    bus.cmd_clear = 1'b0;
    n = 0;
    while (dc.size() == 0 && n < 80000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    checks++; if (wa.size() !== 76800) begin errors++; $display("FAIL clear_count: got %0d required 76800", wa.size()); end
    bad = 0;
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 17'(i) || wd[i] !== 8'h00 || wc[i] !== hs + 1 + i) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL clear_sequence: %0d out-of-order writes required 0", bad); end
    checks++; if (dc.size() !== 1 || dc[0] !== hs + 76801) begin errors++; $display("FAIL clear_done: count %0d required 1 at cycle %0d", dc.size(), hs + 76801); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_pixel();
    test_small_rect();
    test_clamp();
    test_back_to_back();
    test_reset_mid_fill();
`ifdef FB_RECT_CLEAR_EN
    test_clear();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
